// File: rtl/apb_pkg.sv
// Shared APB definitions: slave FSM state encoding and bridge-side bus widths.
package apb_pkg;

    localparam int APB_DATA_W = 8;
    localparam int APB_ADDR_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_WAIT  = 3'b010,
        ST_READY = 3'b100
    } apb_state_t;

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_WIDTH register array: cleared by reset, synchronous write, combinational read.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = APB_DATA_W,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave backed by a small register memory, with a fixed number of wait states
// and error response on out-of-range addresses or unstable access signals.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_W - 1,
    parameter int DATA_WIDTH  = APB_DATA_W,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    apb_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            cnt;
    logic                  err_q;

    logic                  setup;
    logic                  mismatch;
    logic                  addr_ok_q;
    logic                  addr_ok_p;
    logic                  entry_err;
    logic                  mem_we;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;

    assign setup     = PSEL & ~PENABLE;
    assign addr_ok_q = {1'b0, addr_q} < DEPTH_LIM;
    assign addr_ok_p = {1'b0, PADDR} < DEPTH_LIM;
    assign mismatch  = (PADDR != addr_q) | (PWRITE != write_q) | (write_q & (PWDATA != wdata_q));

    // Entering READY from IDLE means the live bus is the transfer; from WAIT it is the latched copy.
    assign rd_idx    = (state == ST_IDLE) ? PADDR[IDX_W-1:0] : addr_q[IDX_W-1:0];
    assign entry_err = (state == ST_IDLE) ? ~addr_ok_p : (err_q | mismatch | ~addr_ok_q);
    assign mem_we    = PREADY & write_q & ~PSLVERR;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (setup) state_nxt = (WAIT_STATES == 0) ? ST_READY : ST_WAIT;
            ST_WAIT:  begin
                if (!PSEL)          state_nxt = ST_IDLE;
                else if (cnt == '0) state_nxt = ST_READY;
            end
            ST_READY: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        PREADY  = (state == ST_READY);
        PSLVERR = (state == ST_READY) & (err_q | mismatch | ~addr_ok_q);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
            PRDATA  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    err_q <= 1'b0;
                    if (setup) begin
                        addr_q  <= PADDR;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                        cnt     <= CNT_INIT;
                    end
                end
                ST_WAIT: begin
                    err_q <= err_q | mismatch;
                    if (cnt != '0) cnt <= cnt - 4'd1;
                end
                default: ;
            endcase
            if (state_nxt == ST_READY) PRDATA <= entry_err ? '0 : rd_data;
        end
    end

    apb_slave_regfile #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .we      (mem_we),
        .waddr   (addr_q[IDX_W-1:0]),
        .wdata   (wdata_q),
        .raddr   (rd_idx),
        .rdata   (rd_data)
    );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench: two slaves (2 and 0 wait states) driven with directed APB transfers.
module tb_apb_slave_mem;

    typedef struct {
        logic       err;
        logic       chk_data;
        logic [7:0] data;
        int         issue;
        int         lat;
        string      name;
    } exp_t;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       psel    [2];
    logic       penable [2];
    logic       pwrite  [2];
    logic [7:0] paddr   [2];
    logic [7:0] pwdata  [2];
    logic [7:0] prdata  [2];
    logic       pready  [2];
    logic       pslverr [2];

    exp_t sb0[$];
    exp_t sb1[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ready_cnt [2];
    int   pulses_before;

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(64), .WAIT_STATES(2)) dut_ws2 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(64), .WAIT_STATES(0)) dut_ws0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every PREADY pulse must match the oldest outstanding expectation for that slave.
    always @(negedge PCLK) begin
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            bit   got;
            if (pready[d] === 1'b1) begin
                ready_cnt[d]++;
                got = 1'b0;
                if (d == 0 && sb0.size() > 0) begin
                    e = sb0.pop_front();
                    got = 1'b1;
                end else if (d == 1 && sb1.size() > 0) begin
                    e = sb1.pop_front();
                    got = 1'b1;
                end
                if (!got) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_pready dut%0d: got PREADY=1, expected no response", d);
                end else begin
                    check_output({e.name, " latency"}, 8'(cyc - e.issue), 8'(e.lat));
                    check_output({e.name, " pslverr"}, {7'b0, pslverr[d]}, {7'b0, e.err});
                    if (e.chk_data) check_output({e.name, " prdata"}, prdata[d], e.data);
                end
            end
        end
    end

    task automatic apply_stimulus(input int d, input logic wr, input logic [7:0] addr,
                                  input logic [7:0] wdata, input logic exp_err,
                                  input logic chk, input logic [7:0] exp_data, input string name,
                                  input int alt_addr = -1, input int alt_wdata = -1);
        exp_t e;
        int   k;
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wdata;
        e.err      = exp_err;
        e.chk_data = chk;
        e.data     = exp_data;
        e.issue    = cyc;
        e.lat      = (d == 0) ? 3 : 1;
        e.name     = name;
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        @(posedge PCLK); #1;
        penable[d] = 1'b1;
        if (alt_addr >= 0)  paddr[d]  = 8'(alt_addr);
        if (alt_wdata >= 0) pwdata[d] = 8'(alt_wdata);
        k = 0;
        @(negedge PCLK);
        while (pready[d] !== 1'b1 && k < 20) begin
            @(negedge PCLK);
            k++;
        end
        if (k >= 20) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s timeout: got no PREADY in 20 cycles, expected PREADY", name);
        end
        @(posedge PCLK); #1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    task automatic wr(input int d, input logic [7:0] addr, input logic [7:0] data,
                      input logic err, input string name);
        apply_stimulus(d, 1'b1, addr, data, err, 1'b0, 8'h00, name);
    endtask

    task automatic rd(input int d, input logic [7:0] addr, input logic [7:0] data,
                      input logic err, input string name);
        apply_stimulus(d, 1'b0, addr, 8'h00, err, 1'b1, data, name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = 8'h00; pwdata[d] = 8'h00; ready_cnt[d] = 0;
        end
        #3;
        check_output("reset pready0",  {7'b0, pready[0]},  8'h00);
        check_output("reset pslverr0", {7'b0, pslverr[0]}, 8'h00);
        check_output("reset prdata0",  prdata[0],          8'h00);
        check_output("reset pready1",  {7'b0, pready[1]},  8'h00);
        check_output("reset pslverr1", {7'b0, pslverr[1]}, 8'h00);
        check_output("reset prdata1",  prdata[1],          8'h00);
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(posedge PCLK); #1;

        $display("[TB] basic write/read with two wait states");
        wr(0, 8'h10, 8'h5A, 1'b0, "t1 write 0x10");
        rd(0, 8'h10, 8'h5A, 1'b0, "t1 read 0x10");
        repeat (3) @(posedge PCLK);
        #1 check_output("t1 prdata hold", prdata[0], 8'h5A);

        $display("[TB] back-to-back with zero wait states");
        wr(1, 8'h00, 8'h11, 1'b0, "t2 write 0x00");
        wr(1, 8'h01, 8'h22, 1'b0, "t2 write 0x01");
        rd(1, 8'h00, 8'h11, 1'b0, "t2 read 0x00");
        rd(1, 8'h01, 8'h22, 1'b0, "t2 read 0x01");

        $display("[TB] address range errors");
        rd(1, 8'h40, 8'h00, 1'b1, "t3 read 0x40");
        wr(1, 8'h40, 8'hFF, 1'b1, "t3 write 0x40");
        rd(1, 8'h00, 8'h11, 1'b0, "t3 read 0x00");
        rd(1, 8'h80, 8'h00, 1'b1, "t3 read 0x80");
        wr(1, 8'h3F, 8'hA5, 1'b0, "t3 write 0x3F");
        rd(1, 8'h3F, 8'hA5, 1'b0, "t3 read 0x3F");

        $display("[TB] unstable access signals");
        wr(0, 8'h05, 8'hA1, 1'b0, "t4 write 0x05");
        wr(0, 8'h06, 8'hB2, 1'b0, "t4 write 0x06");
        apply_stimulus(0, 1'b1, 8'h05, 8'h33, 1'b1, 1'b0, 8'h00, "t4 paddr change", 8'h06, -1);
        rd(0, 8'h05, 8'hA1, 1'b0, "t4 read 0x05");
        rd(0, 8'h06, 8'hB2, 1'b0, "t4 read 0x06");
        apply_stimulus(0, 1'b1, 8'h07, 8'h44, 1'b1, 1'b0, 8'h00, "t4 pwdata change", -1, 8'h45);
        rd(0, 8'h07, 8'h00, 1'b0, "t4 read 0x07");

        $display("[TB] PSEL dropped during wait states");
        pulses_before = ready_cnt[0];
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h08; pwdata[0] = 8'h99;
        @(posedge PCLK); #1 penable[0] = 1'b1;
        @(posedge PCLK); #1 begin psel[0] = 1'b0; penable[0] = 1'b0; end
        repeat (4) @(posedge PCLK);
        #1 check_output("t5 abort pulses", 8'(ready_cnt[0] - pulses_before), 8'h00);
        rd(0, 8'h08, 8'h00, 1'b0, "t5 read 0x08");
        wr(0, 8'h09, 8'h12, 1'b0, "t5 write 0x09");
        rd(0, 8'h09, 8'h12, 1'b0, "t5 read 0x09");

        $display("[TB] access phase without setup is ignored");
        pulses_before = ready_cnt[1];
        psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 8'h02; pwdata[1] = 8'h05;
        repeat (3) @(posedge PCLK);
        #1 begin psel[1] = 1'b0; penable[1] = 1'b0; end
        @(posedge PCLK); #1;
        check_output("ignored pulses", 8'(ready_cnt[1] - pulses_before), 8'h00);
        rd(1, 8'h02, 8'h00, 1'b0, "ignored read 0x02");
        rd(1, 8'h00, 8'h11, 1'b0, "pre-reset read 0x00");

        $display("[TB] reset in the middle of a wait state");
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h20; pwdata[0] = 8'h77;
        @(posedge PCLK); #1 penable[0] = 1'b1;
        #2 PRESETn = 1'b0;
        #1;
        check_output("t6 pready0",  {7'b0, pready[0]},  8'h00);
        check_output("t6 pslverr0", {7'b0, pslverr[0]}, 8'h00);
        check_output("t6 prdata0",  prdata[0],          8'h00);
        check_output("t6 prdata1",  prdata[1],          8'h00);
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(posedge PCLK); #1 PRESETn = 1'b1;
        @(posedge PCLK); #1;
        rd(0, 8'h10, 8'h00, 1'b0, "t6 read 0x10");
        rd(0, 8'h20, 8'h00, 1'b0, "t6 read 0x20");
        rd(1, 8'h00, 8'h00, 1'b0, "t6 read dut1 0x00");

        repeat (2) @(posedge PCLK);
        #1;
        check_output("sb0 drained", 8'(sb0.size()), 8'h00);
        check_output("sb1 drained", 8'(sb1.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
